// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the MIPS pipeline: word type and branch-predictor helpers.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Weakly-taken counter value: MSB set, other bits clear; callers truncate to their width.
    function automatic logic [3:0] bp_cnt_weak_taken(input int unsigned cnt_w);
        return 4'(1) << (cnt_w - 1);
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; when full, a push overwrites the oldest entry.
module return_stack
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  push,
    input  logic  pop,
    input  word_t push_addr,
    output word_t top,
    output logic  valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    word_t            mem_q [DEPTH];
    word_t            mem_d [DEPTH];
    logic             empty, full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PTR_W + 1)'(DEPTH));

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        // Push+pop replaces the top in place unless there is no top to replace.
        if (push && (!pop || empty)) begin
            sp_d        = sp_q + 1'b1;
            mem_d[sp_d] = push_addr;
            cnt_d       = full ? cnt_q : cnt_q + 1'b1;
        end else if (push && pop) begin
            mem_d[sp_q] = push_addr;
        end else if (pop && !empty) begin
            sp_d  = sp_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign valid = !empty;
    assign top   = empty ? '0 : mem_q[sp_q];

endmodule

// File: rtl/branch_predictor.sv
// BTB with saturating-counter direction prediction for fetch.
// Define BP_RAS_EN to add the return-address stack; otherwise ras_top/ras_valid are tied to 0.
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic  CLK,
    input  logic  RST,
    input  word_t lu_pc,
    output logic  pred_hit,
    output logic  pred_taken,
    output word_t pred_target,
    input  logic  upd_en,
    input  word_t upd_pc,
    input  logic  upd_taken,
    input  word_t upd_target,
    input  logic  ras_push,
    input  word_t ras_push_addr,
    input  logic  ras_pop,
    output word_t ras_top,
    output logic  ras_valid
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] BP_CNT_WEAK_TAKEN = CNT_W'(bp_cnt_weak_taken(CNT_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            target;
        logic [CNT_W-1:0] cnt;
    } btb_entry_t;

    btb_entry_t btb_q [ENTRIES];
    btb_entry_t btb_d [ENTRIES];

    logic [IDX_W-1:0] lu_idx, upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       lu_entry, upd_entry;
    logic             upd_hit;

    assign lu_idx   = lu_pc[IDX_W+1:2];
    assign lu_entry = btb_q[lu_idx];

    // Lookup reads registered state only; same-cycle updates appear next cycle.
    assign pred_hit    = lu_entry.valid && (lu_entry.tag == lu_pc[31:IDX_W+2]);
    assign pred_taken  = pred_hit && lu_entry.cnt[CNT_W-1];
    assign pred_target = pred_taken ? lu_entry.target : lu_pc + 32'd4;

    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[31:IDX_W+2];
    assign upd_entry = btb_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    always_comb begin
        btb_d = btb_q;
        if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    btb_d[upd_idx].target = upd_target;
                    if (upd_entry.cnt != CNT_MAX) begin
                        btb_d[upd_idx].cnt = upd_entry.cnt + 1'b1;
                    end
                end else if (upd_entry.cnt != '0) begin
                    btb_d[upd_idx].cnt = upd_entry.cnt - 1'b1;
                end
            end else if (upd_taken) begin
                btb_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: upd_target,
                                   cnt: BP_CNT_WEAK_TAKEN};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
        end else begin
            btb_q <= btb_d;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{upd_pc[1:0]};

`ifdef BP_RAS_EN
    return_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_return_stack (
        .CLK       (CLK),
        .RST       (RST),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_addr (ras_push_addr),
        .top       (ras_top),
        .valid     (ras_valid)
    );
`else
    localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
    logic unused_ras;
    assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
    assign ras_top    = '0;
    assign ras_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expectations, a negedge monitor checks them.
module tb_branch_predictor;
    import cpu_types_pkg::*;

`ifdef BP_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic  CLK = 1'b0;
    logic  RST;
    word_t lu_pc;
    logic  pred_hit, pred_taken;
    word_t pred_target;
    logic  upd_en, upd_taken;
    word_t upd_pc, upd_target;
    logic  ras_push, ras_pop;
    word_t ras_push_addr, ras_top;
    logic  ras_valid;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string name;
        logic  hit;
        logic  taken;
        word_t tgt;
        word_t rtop;
        logic  rvalid;
    } exp_t;

    exp_t exp_q[$];

    branch_predictor #(
        .ENTRIES   (16),
        .CNT_W     (2),
        .RAS_DEPTH (4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .lu_pc         (lu_pc),
        .pred_hit      (pred_hit),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .upd_en        (upd_en),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .ras_push      (ras_push),
        .ras_push_addr (ras_push_addr),
        .ras_pop       (ras_pop),
        .ras_top       (ras_top),
        .ras_valid     (ras_valid)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string nm, input string what, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, what, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so one expectation is due each cycle it was queued.
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "hit", 32'(pred_hit), 32'(e.hit));
            cmp(e.name, "taken", 32'(pred_taken), 32'(e.taken));
            cmp(e.name, "target", pred_target, e.tgt);
            cmp(e.name, "ras_valid", 32'(ras_valid), 32'(e.rvalid));
            cmp(e.name, "ras_top", ras_top, e.rtop);
        end
    end

    task automatic step(input string nm, input logic h, input logic t, input word_t tgt,
                        input word_t rt, input logic rv);
        exp_t e;
        e.name   = nm;
        e.hit    = h;
        e.taken  = t;
        e.tgt    = tgt;
        e.rtop   = RAS_ON ? rt : 32'h0;
        e.rvalid = RAS_ON ? rv : 1'b0;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        upd_en   = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
    endtask

    task automatic upd(input word_t pc, input logic tk, input word_t tgt);
        upd_en     = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; lu_pc = 32'h0; upd_en = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
        upd_target = 32'h0; ras_push = 1'b0; ras_pop = 1'b0; ras_push_addr = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        lu_pc = 32'h40;         step("reset_lookup", 0, 0, 32'h44, 0, 0);
        lu_pc = 32'hFFFF_FFFC;  step("wrap", 0, 0, 32'h0, 0, 0);
        // Allocation is not visible in its own cycle.
        lu_pc = 32'h40; upd(32'h40, 1, 32'h80); step("alloc_same_cycle", 0, 0, 32'h44, 0, 0);
        step("alloc_next", 1, 1, 32'h80, 0, 0);
        upd(32'h40, 0, 32'h0);  step("cnt10", 1, 1, 32'h80, 0, 0);
        upd(32'h40, 0, 32'h0);  step("cnt01", 1, 0, 32'h44, 0, 0);
        upd(32'h40, 0, 32'h0);  step("cnt00", 1, 0, 32'h44, 0, 0);
        upd(32'h40, 1, 32'h80); step("cnt00_sat", 1, 0, 32'h44, 0, 0);
        upd(32'h40, 1, 32'h80); step("cnt01_up", 1, 0, 32'h44, 0, 0);
        upd(32'h40, 1, 32'h90); step("cnt10_up", 1, 1, 32'h80, 0, 0);
        upd(32'h40, 1, 32'h90); step("cnt11", 1, 1, 32'h90, 0, 0);
        upd(32'h40, 0, 32'h0);  step("cnt11_sat", 1, 1, 32'h90, 0, 0);
        upd(32'h40, 0, 32'h0);  step("cnt10_dn", 1, 1, 32'h90, 0, 0);
        step("cnt01_dn", 1, 0, 32'h44, 0, 0);
        // 0x80 and 0xC0 alias 0x40's index with different tags.
        lu_pc = 32'h80; upd(32'h80, 1, 32'h100); step("alias_alloc", 0, 0, 32'h84, 0, 0);
        lu_pc = 32'h40;         step("alias_old_miss", 0, 0, 32'h44, 0, 0);
        lu_pc = 32'h80; upd(32'hC0, 0, 32'h0); step("alias_new_hit", 1, 1, 32'h100, 0, 0);
        step("miss_nt_nochange", 1, 1, 32'h100, 0, 0);
        lu_pc = 32'h44; upd(32'h44, 1, 32'h200); step("idx1_alloc", 0, 0, 32'h48, 0, 0);
        step("idx1_hit", 1, 1, 32'h200, 0, 0);
        lu_pc = 32'h80;         step("idx0_kept", 1, 1, 32'h100, 0, 0);
        RST = 1'b1; lu_pc = 32'h80; upd(32'h40, 1, 32'h80); step("rst_pre", 1, 1, 32'h100, 0, 0);
        lu_pc = 32'h40;         step("rst_drop_upd", 0, 0, 32'h44, 0, 0);
        lu_pc = 32'h80;         step("rst_cleared", 0, 0, 32'h84, 0, 0);

        lu_pc = 32'h40;
        ras_push = 1; ras_push_addr = 32'h10; step("push10", 0, 0, 32'h44, 32'h0, 0);
        ras_push = 1; ras_push_addr = 32'h20; step("push20", 0, 0, 32'h44, 32'h10, 1);
        ras_push = 1; ras_push_addr = 32'h30; step("push30", 0, 0, 32'h44, 32'h20, 1);
        ras_push = 1; ras_push_addr = 32'h40; step("push40", 0, 0, 32'h44, 32'h30, 1);
        ras_push = 1; ras_push_addr = 32'h50; step("push50", 0, 0, 32'h44, 32'h40, 1);
        ras_pop = 1;                          step("pop1", 0, 0, 32'h44, 32'h50, 1);
        ras_pop = 1;                          step("pop2", 0, 0, 32'h44, 32'h40, 1);
        ras_pop = 1;                          step("pop3", 0, 0, 32'h44, 32'h30, 1);
        ras_pop = 1;                          step("pop4", 0, 0, 32'h44, 32'h20, 1);
        ras_pop = 1;                          step("pop_empty", 0, 0, 32'h44, 32'h0, 0);
        step("still_empty", 0, 0, 32'h44, 32'h0, 0);
        ras_push = 1; ras_push_addr = 32'hA0; step("pushA0", 0, 0, 32'h44, 32'h0, 0);
        ras_push = 1; ras_push_addr = 32'hB0; step("pushB0", 0, 0, 32'h44, 32'hA0, 1);
        ras_push = 1; ras_pop = 1; ras_push_addr = 32'hC0;
        step("pushpop", 0, 0, 32'h44, 32'hB0, 1);
        step("replaced", 0, 0, 32'h44, 32'hC0, 1);
        ras_pop = 1;                          step("popC0", 0, 0, 32'h44, 32'hC0, 1);
        ras_pop = 1;                          step("popA0", 0, 0, 32'h44, 32'hA0, 1);
        ras_push = 1; ras_pop = 1; ras_push_addr = 32'hD0;
        step("pushpop_empty", 0, 0, 32'h44, 32'h0, 0);
        RST = 1; ras_push = 1; ras_push_addr = 32'hE0;
        step("ras_rst_pre", 0, 0, 32'h44, 32'hD0, 1);
        step("ras_rst_post", 0, 0, 32'h44, 32'h0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
